// File: rtl/pixel_scan_ctrl.sv
// pixel_scan_ctrl: walks the pixel mux select 0..NUM_PIX-1 and streams captures.
// Define PIXEL_SUM_EN to add the per-frame frame_sum accumulator.
`ifndef PIX_WIDTH
`define PIX_WIDTH 8
`endif

module pixel_scan_ctrl #(
  parameter int NUM_PIX = 50,
  parameter int SEL_W   = 6,
  parameter int PIX_W   = `PIX_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic                   busy,
  output logic [SEL_W-1:0]       Pixel_Select,
  input  logic [PIX_W-1:0]       Selected_Pixel,
  output logic [PIX_W-1:0]       out_data,
  output logic [SEL_W-1:0]       out_idx,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
`ifdef PIXEL_SUM_EN
  output logic [PIX_W+SEL_W-1:0] frame_sum,
`endif
  output logic                   done
);

  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_PIX - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DRAIN
  } state_t;

  state_t state;
  state_t state_nx;
  logic   load;
  logic   accept;
  logic   at_last;

  assign at_last  = (Pixel_Select == LAST_SEL);
  assign load     = (state == S_SCAN) && (!out_valid || out_ready);
  assign accept   = out_valid && out_ready;
  assign busy     = (state != S_IDLE);
  assign out_last = out_valid && (out_idx == LAST_SEL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (start) state_nx = S_SCAN;
      S_SCAN:  if (load && at_last) state_nx = S_DRAIN;
      S_DRAIN: if (accept) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // The select only advances on a capture, so the mux output has a full
  // cycle to settle before it is sampled; it never steps past the last pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Pixel_Select <= '0;
      out_data     <= '0;
      out_idx      <= '0;
      out_valid    <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        out_data  <= Selected_Pixel;
        out_idx   <= Pixel_Select;
        out_valid <= 1'b1;
        if (!at_last) begin
          Pixel_Select <= Pixel_Select + 1'b1;
        end
      end
      if ((state == S_DRAIN) && accept) begin
        out_valid    <= 1'b0;
        done         <= 1'b1;
        Pixel_Select <= '0;
      end
    end
  end

`ifdef PIXEL_SUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_sum <= '0;
    end else if ((state == S_IDLE) && start) begin
      frame_sum <= '0;
    end else if (accept) begin
      frame_sum <= frame_sum + {{SEL_W{1'b0}}, out_data};
    end
  end
`endif

endmodule

// File: tb/tb_pixel_scan_ctrl.sv
// tb_pixel_scan_ctrl: randomized scans against a queue scoreboard.
// Covers backpressure, ignored start, reset abort, back-to-back and frame_sum.
`timescale 1ns/1ps

module tb_pixel_scan_ctrl;

  localparam int NUM_PIX = 50;
  localparam int SEL_W   = 6;
  localparam int PIX_W   = 8;

  typedef struct {
    logic [PIX_W-1:0] d;
    logic [SEL_W-1:0] i;
    logic             l;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             busy;
  logic [SEL_W-1:0] Pixel_Select;
  logic [PIX_W-1:0] Selected_Pixel;
  logic [PIX_W-1:0] out_data;
  logic [SEL_W-1:0] out_idx;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic             done;
`ifdef PIXEL_SUM_EN
  logic [PIX_W+SEL_W-1:0] frame_sum;
`endif

  logic [PIX_W-1:0] pix [64];
  assign Selected_Pixel = pix[Pixel_Select];

  pixel_scan_ctrl #(
    .NUM_PIX(NUM_PIX),
    .SEL_W  (SEL_W),
    .PIX_W  (PIX_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .busy          (busy),
    .Pixel_Select  (Pixel_Select),
    .Selected_Pixel(Selected_Pixel),
    .out_data      (out_data),
    .out_idx       (out_idx),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_last      (out_last),
`ifdef PIXEL_SUM_EN
    .frame_sum     (frame_sum),
`endif
    .done          (done)
  );

  always #5 clk = ~clk;

  int    checks    = 0;
  int    failures  = 0;
  int    beats     = 0;
  int    done_seen = 0;
  int    exp_dones = 0;
  int    rdy_mode  = 0;
  int    rcnt      = 0;
  beat_t sb_q[$];
  int    sum_q[$];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event t=%0t", nm, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: a scan of the current mux inputs yields every pixel in
  // index order, last flag on the final one, sum of all pixels.
  task automatic push_scan();
    int s;
    s = 0;
    for (int k = 0; k < NUM_PIX; k++) begin
      sb_q.push_back('{pix[k], SEL_W'(k), (k == NUM_PIX - 1)});
      s += int'(pix[k]);
    end
    sum_q.push_back(s);
    exp_dones++;
    beats = 0;
  endtask

  task automatic start_scan();
    start = 1'b1;
    step();
    start = 1'b0;
    push_scan();
    chk("busy_after_start", busy, 1);
`ifdef PIXEL_SUM_EN
    chk("sum_cleared", frame_sum, 0);
`endif
  endtask

  task automatic wait_done(input int bound, output int n);
    n = 0;
    while (1) begin
      step();
      n++;
      if (done) break;
      if (n >= bound) begin
        fail_now("wait_done");
        break;
      end
    end
  endtask

  task automatic wait_beats(input int target);
    int c;
    c = 0;
    while (beats < target && c < 2000) begin
      step();
      c++;
    end
    if (beats < target) fail_now("wait_beats");
  endtask

  task automatic rand_pix();
    for (int k = 0; k < 64; k++) pix[k] = PIX_W'($urandom);
  endtask

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = (rcnt % 3 == 0);
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
    rcnt++;
  end

  logic             pv_stall = 1'b0;
  logic [PIX_W-1:0] pv_data;
  logic [SEL_W-1:0] pv_idx;
  logic             pv_last;

  always @(negedge clk) begin
    if (!rst_n) begin
      pv_stall = 1'b0;
    end else begin
      chk("sel_range", (Pixel_Select < NUM_PIX), 1);
      if (pv_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, pv_data);
        chk("stall_idx", out_idx, pv_idx);
        chk("stall_last", out_last, pv_last);
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          chk("extra_beat", out_idx, -1);
        end else begin
          beat_t e;
          e = sb_q.pop_front();
          chk("beat_data", out_data, e.d);
          chk("beat_idx", out_idx, e.i);
          chk("beat_last", out_last, e.l);
        end
        beats++;
      end
      if (done) begin
        done_seen++;
        chk("done_after_last", sb_q.size(), 0);
        if (sum_q.size() != 0) begin
          int s;
          s = sum_q.pop_front();
`ifdef PIXEL_SUM_EN
          chk("frame_sum", frame_sum, s);
`endif
        end
      end
      pv_stall = out_valid && !out_ready;
      pv_data  = out_data;
      pv_idx   = out_idx;
      pv_last  = out_last;
    end
  end

  initial begin
    int n;
    rst_n     = 1'b0;
    start     = 1'b0;
    out_ready = 1'b0;
    rand_pix();
    repeat (3) step();
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sel", Pixel_Select, 0);
    chk("rst_data", out_data, 0);
    chk("rst_idx", out_idx, 0);
    chk("rst_last", out_last, 0);
    chk("rst_done", done, 0);
`ifdef PIXEL_SUM_EN
    chk("rst_sum", frame_sum, 0);
`endif
    rst_n = 1'b1;
    step();

    // Full scan without backpressure: done after edge N+NUM_PIX+1.
    for (int k = 0; k < 64; k++) pix[k] = PIX_W'(k + 10);
    rdy_mode = 0;
    start_scan();
    wait_done(500, n);
    chk("done_latency", n, NUM_PIX + 1);
    chk("busy_at_done", busy, 0);
    step();
    chk("done_one_cycle", done, 0);

    // Backpressure, one ready cycle in three.
    rand_pix();
    rdy_mode = 1;
    rcnt = 0;
    start_scan();
    wait_done(1000, n);
    step();

    // Start pulses while busy must be ignored.
    rand_pix();
    rdy_mode = 2;
    start_scan();
    wait_beats(5);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_beats(30);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(1000, n);
    repeat (4) step();

    // Asynchronous reset mid-scan aborts without done.
    rand_pix();
    rdy_mode = 0;
    start_scan();
    wait_beats(20);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("abort_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_sel", Pixel_Select, 0);
    chk("abort_done", done, 0);
    sb_q.delete();
    sum_q.delete();
    exp_dones--;
    step();
    step();
    rst_n = 1'b1;
    repeat (3) step();
    start_scan();
    wait_done(500, n);
    step();

    // Back-to-back scans with start held high.
    rand_pix();
    start = 1'b1;
    step();
    push_scan();
    wait_done(500, n);
    step();
    start = 1'b0;
    push_scan();
    chk("b2b_gap_valid", out_valid, 0);
`ifdef PIXEL_SUM_EN
    chk("b2b_sum_cleared", frame_sum, 0);
`endif
    step();
    chk("b2b_first_valid", out_valid, 1);
    chk("b2b_first_idx", out_idx, 0);
    wait_done(500, n);
    step();

    // Saturated pixels: sum is 50 * 255.
    for (int k = 0; k < 64; k++) pix[k] = 8'hFF;
    rdy_mode = 2;
    start_scan();
    wait_done(1000, n);
`ifdef PIXEL_SUM_EN
    chk("sum_all_ff", frame_sum, 12750);
    step();
    chk("sum_hold", frame_sum, 12750);
`endif

    for (int r = 0; r < 3; r++) begin
      rand_pix();
      rdy_mode = r;
      repeat ($urandom_range(1, 4)) step();
      start_scan();
      wait_done(1000, n);
    end

    repeat (5) step();
    chk("done_count", done_seen, exp_dones);
    chk("sb_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
